// File: rtl/dll_tx_arb.sv
// Transmit-side scheduler merging Ack/Nak DLLPs, FC DLLPs and TLP beats onto the EP beat stream.
// Optional beat statistics (tlp_cnt_o, dllp_cnt_o, stats_clr_i) under `define DLL_TX_ARB_STATS_EN.
module dll_tx_arb #(
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned DLLP_MAX_RUN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              link_active_i,
  input  logic              ack_valid_i,
  input  logic [63:0]       ack_dllp_i,
  output logic              ack_ready_o,
  input  logic              fc_valid_i,
  input  logic [63:0]       fc_dllp_i,
  output logic              fc_ready_o,
  input  logic              tlp_valid_i,
  input  logic [DATA_W-1:0] tlp_data_i,
  input  logic              tlp_last_i,
  output logic              tlp_ready_o,
  output logic              ep_valid_o,
  output logic [DATA_W-1:0] ep_data_o,
  output logic              ep_is_dllp_o,
`ifdef DLL_TX_ARB_STATS_EN
  output logic [31:0]       tlp_cnt_o,
  output logic [31:0]       dllp_cnt_o,
  input  logic              stats_clr_i,
`endif
  input  logic              ep_ready_i
);

  localparam int unsigned RUN_W = $clog2(DLLP_MAX_RUN + 1);

  typedef enum logic {S_IDLE, S_TLP} state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             load_en, tlp_elig, force_tlp, link_drop;
  logic             gnt_ack, gnt_fc, gnt_tlp;
  logic             ack_hs, fc_hs, tlp_hs;

  // State and run-counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Grant selection, ready generation, next state and run count
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    gnt_ack     = 1'b0;
    gnt_fc      = 1'b0;
    gnt_tlp     = 1'b0;
    load_en     = !ep_valid_o || ep_ready_i;
    tlp_elig    = link_active_i && tlp_valid_i;
    force_tlp   = tlp_elig && (run_q == RUN_W'(DLLP_MAX_RUN));
    link_drop   = (state_q == S_TLP) && !link_active_i;

    if (state_q == S_TLP)  gnt_tlp = tlp_elig;
    else if (force_tlp)    gnt_tlp = 1'b1;
    else if (ack_valid_i)  gnt_ack = 1'b1;
    else if (fc_valid_i)   gnt_fc  = 1'b1;
    else                   gnt_tlp = tlp_elig;

    ack_ready_o = rst_n && load_en && gnt_ack;
    fc_ready_o  = rst_n && load_en && gnt_fc;
    tlp_ready_o = rst_n && load_en && gnt_tlp;
    ack_hs      = ack_ready_o;
    fc_hs       = fc_ready_o;
    tlp_hs      = tlp_ready_o;

    if (link_drop) begin
      state_d = S_IDLE;
      run_d   = '0;
    end else begin
      if (tlp_hs) state_d = tlp_last_i ? S_IDLE : S_TLP;
      if (tlp_hs || !tlp_valid_i)
        run_d = '0;
      else if ((ack_hs || fc_hs) && link_active_i && (run_q != RUN_W'(DLLP_MAX_RUN)))
        run_d = run_q + RUN_W'(1);
    end
  end

  // Output beat register; a held TLP beat is discarded when the link drops mid-packet
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ep_valid_o   <= 1'b0;
      ep_data_o    <= '0;
      ep_is_dllp_o <= 1'b0;
    end else if (link_drop && !ep_is_dllp_o) begin
      ep_valid_o   <= 1'b0;
    end else if (load_en) begin
      if (ack_hs) begin
        ep_valid_o   <= 1'b1;
        ep_data_o    <= DATA_W'(ack_dllp_i);
        ep_is_dllp_o <= 1'b1;
      end else if (fc_hs) begin
        ep_valid_o   <= 1'b1;
        ep_data_o    <= DATA_W'(fc_dllp_i);
        ep_is_dllp_o <= 1'b1;
      end else if (tlp_hs) begin
        ep_valid_o   <= 1'b1;
        ep_data_o    <= tlp_data_i;
        ep_is_dllp_o <= 1'b0;
      end else begin
        ep_valid_o   <= 1'b0;
      end
    end
  end

`ifdef DLL_TX_ARB_STATS_EN
  // Completed-TLP and DLLP counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tlp_cnt_o  <= '0;
      dllp_cnt_o <= '0;
    end else if (stats_clr_i) begin
      tlp_cnt_o  <= '0;
      dllp_cnt_o <= '0;
    end else begin
      if (tlp_hs && tlp_last_i) tlp_cnt_o  <= tlp_cnt_o + 32'd1;
      if (ack_hs || fc_hs)      dllp_cnt_o <= dllp_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dll_tx_arb.sv
// Directed self-checking bench for dll_tx_arb (DATA_W=256, DLLP_MAX_RUN=2).
// Statistics checks compile in only when DLL_TX_ARB_STATS_EN is defined.
module tb_dll_tx_arb;

  localparam int unsigned DATA_W = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              link_active_i;
  logic              ack_valid_i;
  logic [63:0]       ack_dllp_i;
  logic              ack_ready_o;
  logic              fc_valid_i;
  logic [63:0]       fc_dllp_i;
  logic              fc_ready_o;
  logic              tlp_valid_i;
  logic [DATA_W-1:0] tlp_data_i;
  logic              tlp_last_i;
  logic              tlp_ready_o;
  logic              ep_valid_o;
  logic [DATA_W-1:0] ep_data_o;
  logic              ep_is_dllp_o;
  logic              ep_ready_i;
`ifdef DLL_TX_ARB_STATS_EN
  logic [31:0]       tlp_cnt_o;
  logic [31:0]       dllp_cnt_o;
  logic              stats_clr_i;
`endif

  int errors = 0;
  int checks = 0;

  dll_tx_arb #(.DATA_W(DATA_W), .DLLP_MAX_RUN(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .link_active_i (link_active_i),
    .ack_valid_i   (ack_valid_i),
    .ack_dllp_i    (ack_dllp_i),
    .ack_ready_o   (ack_ready_o),
    .fc_valid_i    (fc_valid_i),
    .fc_dllp_i     (fc_dllp_i),
    .fc_ready_o    (fc_ready_o),
    .tlp_valid_i   (tlp_valid_i),
    .tlp_data_i    (tlp_data_i),
    .tlp_last_i    (tlp_last_i),
    .tlp_ready_o   (tlp_ready_o),
    .ep_valid_o    (ep_valid_o),
    .ep_data_o     (ep_data_o),
    .ep_is_dllp_o  (ep_is_dllp_o),
`ifdef DLL_TX_ARB_STATS_EN
    .tlp_cnt_o     (tlp_cnt_o),
    .dllp_cnt_o    (dllp_cnt_o),
    .stats_clr_i   (stats_clr_i),
`endif
    .ep_ready_i    (ep_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Checks that the registered output holds the given beat
  task automatic chk_beat(input string tag, input logic is_dllp, input logic [DATA_W-1:0] data);
    chk({tag, ".valid"}, DATA_W'(ep_valid_o), DATA_W'(1'b1));
    chk({tag, ".dllp"}, DATA_W'(ep_is_dllp_o), DATA_W'(is_dllp));
    chk({tag, ".data"}, ep_data_o, data);
  endtask

  logic [DATA_W-1:0] b0, b1, b2, b3, t1;
  logic [63:0]       ack_v, fc_v;

  initial begin
    b0 = {64'hB0B0_0000_0000_0001, 64'h1, 64'h2, 64'h3};
    b1 = {64'hB1B1_0000_0000_0001, 64'h4, 64'h5, 64'h6};
    b2 = {64'hB2B2_0000_0000_0001, 64'h7, 64'h8, 64'h9};
    b3 = {64'hB3B3_0000_0000_0001, 64'hA, 64'hB, 64'hC};
    t1 = {64'h7171_7171_7171_7171, 64'hD, 64'hE, 64'hF};
    ack_v = 64'hACAC_0000_1234_5678;
    fc_v  = 64'hFCFC_0000_9ABC_DEF0;

    rst_n = 1'b0; link_active_i = 1'b0; ack_valid_i = 1'b1; ack_dllp_i = ack_v;
    fc_valid_i = 1'b0; fc_dllp_i = fc_v; tlp_valid_i = 1'b0; tlp_data_i = '0;
    tlp_last_i = 1'b0; ep_ready_i = 1'b1;
`ifdef DLL_TX_ARB_STATS_EN
    stats_clr_i = 1'b0;
`endif

    // Reset
    tick(); tick();
    chk("rst.valid", DATA_W'(ep_valid_o), '0);
    chk("rst.data", ep_data_o, '0);
    chk("rst.dllp", DATA_W'(ep_is_dllp_o), '0);
    chk("rst.ack_ready", DATA_W'(ack_ready_o), '0);
    rst_n = 1'b1; ack_valid_i = 1'b0;
    tick();

    // Link down: only FC DLLPs flow
    fc_valid_i = 1'b1; tlp_valid_i = 1'b1; tlp_data_i = t1; tlp_last_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fc_dllp_i = 64'hF000 + 64'(i);
      settle();
      chk("ld.fc_ready", DATA_W'(fc_ready_o), DATA_W'(1'b1));
      chk("ld.tlp_ready", DATA_W'(tlp_ready_o), '0);
      tick();
      chk_beat("ld.beat", 1'b1, DATA_W'(64'hF000 + 64'(i)));
    end
    fc_valid_i = 1'b0; fc_dllp_i = fc_v;
    settle();
    chk("ld.tlp_ready_idle", DATA_W'(tlp_ready_o), '0);
    tick();
    chk("ld.empty", DATA_W'(ep_valid_o), '0);
    tlp_valid_i = 1'b0;
    tick();

    // Priority: ack, fc, tlp on consecutive cycles
    link_active_i = 1'b1;
    ack_valid_i = 1'b1; fc_valid_i = 1'b1; tlp_valid_i = 1'b1; tlp_data_i = t1; tlp_last_i = 1'b1;
    settle();
    chk("pri.ack_ready", DATA_W'(ack_ready_o), DATA_W'(1'b1));
    chk("pri.fc_ready0", DATA_W'(fc_ready_o), '0);
    tick();
    chk_beat("pri.ack", 1'b1, DATA_W'(ack_v));
    ack_valid_i = 1'b0;
    settle();
    chk("pri.fc_ready", DATA_W'(fc_ready_o), DATA_W'(1'b1));
    tick();
    chk_beat("pri.fc", 1'b1, DATA_W'(fc_v));
    fc_valid_i = 1'b0;
    settle();
    chk("pri.tlp_ready", DATA_W'(tlp_ready_o), DATA_W'(1'b1));
    tick();
    chk_beat("pri.tlp", 1'b0, t1);
    tlp_valid_i = 1'b0;
    tick();
    chk("pri.empty", DATA_W'(ep_valid_o), '0);

    // TLP atomicity: ack raised mid-packet waits for the last beat
    tlp_valid_i = 1'b1; tlp_data_i = b0; tlp_last_i = 1'b0;
    tick();
    chk_beat("atom.b0", 1'b0, b0);
    tlp_data_i = b1; ack_valid_i = 1'b1;
    settle();
    chk("atom.ack_wait1", DATA_W'(ack_ready_o), '0);
    tick();
    chk_beat("atom.b1", 1'b0, b1);
    tlp_data_i = b2;
    settle();
    chk("atom.ack_wait2", DATA_W'(ack_ready_o), '0);
    tick();
    chk_beat("atom.b2", 1'b0, b2);
    tlp_data_i = b3; tlp_last_i = 1'b1;
    settle();
    chk("atom.ack_wait3", DATA_W'(ack_ready_o), '0);
    chk("atom.tlp_ready3", DATA_W'(tlp_ready_o), DATA_W'(1'b1));
    tick();
    chk_beat("atom.b3", 1'b0, b3);
    tlp_valid_i = 1'b0;
    settle();
    chk("atom.ack_ready", DATA_W'(ack_ready_o), DATA_W'(1'b1));
    tick();
    chk_beat("atom.ack", 1'b1, DATA_W'(ack_v));
    ack_valid_i = 1'b0;
    tick();

    // Starvation bound: fc, fc, tlp repeating
    fc_valid_i = 1'b1; tlp_valid_i = 1'b1; tlp_data_i = t1; tlp_last_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("starve.tlp_ready", DATA_W'(tlp_ready_o), DATA_W'(i % 3 == 2));
      tick();
      chk("starve.dllp", DATA_W'(ep_is_dllp_o), DATA_W'(i % 3 != 2));
    end
    fc_valid_i = 1'b0; tlp_valid_i = 1'b0;
    tick();
    chk("starve.empty", DATA_W'(ep_valid_o), '0);

    // Backpressure: held beat stays, nothing accepted, then resumes
    tlp_valid_i = 1'b1; tlp_data_i = b0; tlp_last_i = 1'b0;
    tick();
    chk_beat("bp.b0", 1'b0, b0);
    ep_ready_i = 1'b0; tlp_data_i = b1; tlp_last_i = 1'b1; fc_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp.tlp_ready", DATA_W'(tlp_ready_o), '0);
      chk("bp.fc_ready", DATA_W'(fc_ready_o), '0);
      tick();
      chk_beat("bp.hold", 1'b0, b0);
    end
    ep_ready_i = 1'b1;
    settle();
    chk("bp.tlp_resume", DATA_W'(tlp_ready_o), DATA_W'(1'b1));
    tick();
    chk_beat("bp.b1", 1'b0, b1);
    tlp_valid_i = 1'b0;
    tick();
    chk_beat("bp.fc", 1'b1, DATA_W'(fc_v));
    fc_valid_i = 1'b0;
    tick();
    chk("bp.empty", DATA_W'(ep_valid_o), '0);

    // Link drop mid-TLP with the beat stalled downstream
    tlp_valid_i = 1'b1; tlp_data_i = b0; tlp_last_i = 1'b0;
    tick();
    tlp_data_i = b1;
    tick();
    chk_beat("drop.b1", 1'b0, b1);
    link_active_i = 1'b0; ep_ready_i = 1'b0; tlp_data_i = b2; fc_valid_i = 1'b1;
    settle();
    chk("drop.tlp_ready", DATA_W'(tlp_ready_o), '0);
    chk("drop.fc_ready_locked", DATA_W'(fc_ready_o), '0);
    tick();
    chk("drop.valid", DATA_W'(ep_valid_o), '0);
    settle();
    chk("drop.fc_ready", DATA_W'(fc_ready_o), DATA_W'(1'b1));
    ep_ready_i = 1'b1;
    tick();
    chk_beat("drop.fc", 1'b1, DATA_W'(fc_v));
    fc_valid_i = 1'b0; tlp_valid_i = 1'b0;
    tick();
    chk("drop.empty", DATA_W'(ep_valid_o), '0);

`ifdef DLL_TX_ARB_STATS_EN
    // Completed TLPs: pri 1, atom 1, starve 2, bp 1; DLLPs: 3+2+1+4+1+1
    chk("stats.tlp", DATA_W'(tlp_cnt_o), DATA_W'(32'd5));
    chk("stats.dllp", DATA_W'(dllp_cnt_o), DATA_W'(32'd12));
    link_active_i = 1'b1; ack_valid_i = 1'b1; stats_clr_i = 1'b1;
    tick();
    stats_clr_i = 1'b0; ack_valid_i = 1'b0;
    chk("stats.clr_tlp", DATA_W'(tlp_cnt_o), '0);
    chk("stats.clr_dllp", DATA_W'(dllp_cnt_o), '0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
